dm_access_unit: RTL and testbench

Load/store access unit that sits between the MEM pipeline stage and the word-organised data memory. It accepts one byte/halfword/word request at a time over a valid/ready handshake and checks alignment and range. It drives the memory's word port, sub-word stores using a two-cycle read-modify-write, and returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/dm_access_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// dm_access_unit
//   Load/store access unit between the MEM pipeline stage and a word-organised
//   data memory. One request is accepted at a time over a valid/ready handshake.
//   The request is checked for alignment, range and size before any memory access.
//   Loads return a lane extended to 32 bits with sign or zero fill.
//   Word stores write directly.
//   Byte and halfword stores use a read-modify-write that spans the ACCESS and
//   MERGE states.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE and out of reset)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved (error)
//   req_sign          loads: 1 = sign-extend, 0 = zero-extend
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   req_pc            issuing PC, forwarded on mem_pc
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          misaligned / out-of-range / reserved size
//   mem_we            memory write enable
//   mem_addr          word-aligned byte address
//   mem_wd            write data
//   mem_pc            latched PC
//   mem_rd            combinational read data of the word at mem_addr
module dm_access_unit #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE     = 2'b00;
  localparam logic [1:0]  SZ_HALF     = 2'b01;
  localparam logic [1:0]  SZ_WORD     = 2'b10;
  localparam logic [31:0] MEM_WORDS_C = 32'(MEM_WORDS);

  state_t      state_r, state_next_s;
  logic        we_r, sign_r;
  logic [1:0]  size_r, off_r;
  logic [15:0] wdata_r;
  logic [31:0] mem_addr_r, mem_pc_r, mem_wd_r, resp_rdata_r;
  logic        mem_we_r, resp_valid_r, resp_err_r;
  logic        accept_s, req_err_s;
  logic        mem_we_next_s, resp_valid_next_s, resp_err_next_s;
  logic [31:0] mem_wd_next_s, resp_rdata_next_s;

  // Select the addressed little-endian lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = off[1] ? word[31:16] : word[15:0];
    r = 32'h0000_0000;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    case (size)
      SZ_BYTE: r = {{24{sign & b[7]}}, b};
      SZ_HALF: r = {{16{sign & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a word and leave the other bytes unchanged.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [15:0] data);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          2'd3:    r[31:24] = data[7:0];
          default: r = word;
        endcase
      end
      SZ_HALF: begin
        if (off[1]) begin
          r[31:16] = data;
        end else begin
          r[15:0] = data;
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept_s   = (state_r == ST_IDLE) && req_valid;
  assign req_ready  = (state_r == ST_IDLE) && !reset;
  // The write enable is gated by reset so that an abandoned request cannot
  // write in the reset cycle.
  assign mem_we     = mem_we_r && !reset;
  assign mem_addr   = mem_addr_r;
  assign mem_wd     = mem_wd_r;
  assign mem_pc     = mem_pc_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Check the incoming request for reserved size, misalignment and range.
  always_comb begin
    req_err_s = 1'b0;
    if (req_size == 2'b11) begin
      req_err_s = 1'b1;
    end else if ((req_size == SZ_HALF) && req_addr[0]) begin
      req_err_s = 1'b1;
    end else if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
      req_err_s = 1'b1;
    end else if ({2'b00, req_addr[31:2]} >= MEM_WORDS_C) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = 1'b0;
    end
  end

  // Compute the next state and the next values of all registered outputs.
  // Outputs are registered, so each value is set on the transition into the
  // state in which it must appear.
  always_comb begin
    state_next_s      = state_r;
    mem_we_next_s     = 1'b0;
    mem_wd_next_s     = mem_wd_r;
    resp_valid_next_s = 1'b0;
    resp_err_next_s   = 1'b0;
    resp_rdata_next_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_next_s      = ST_RESP;
            resp_valid_next_s = 1'b1;
            resp_err_next_s   = 1'b1;
          end else begin
            state_next_s = ST_ACCESS;
            if (req_we && (req_size == SZ_WORD)) begin
              mem_we_next_s = 1'b1;
              mem_wd_next_s = req_wdata;
            end else begin
              mem_we_next_s = 1'b0;
            end
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (we_r && (size_r != SZ_WORD)) begin
          // Sub-word store: read the old word now and write the merged word in MERGE.
          state_next_s  = ST_MERGE;
          mem_we_next_s = 1'b1;
          mem_wd_next_s = merge_lane(mem_rd, size_r, off_r, wdata_r);
        end else if (we_r) begin
          state_next_s      = ST_RESP;
          resp_valid_next_s = 1'b1;
        end else begin
          state_next_s      = ST_RESP;
          resp_valid_next_s = 1'b1;
          resp_rdata_next_s = load_extend(mem_rd, size_r, off_r, sign_r);
        end
      end
      ST_MERGE: begin
        state_next_s      = ST_RESP;
        resp_valid_next_s = 1'b1;
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register, registered outputs and the request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      sign_r       <= 1'b0;
      size_r       <= 2'b00;
      off_r        <= 2'b00;
      wdata_r      <= 16'h0000;
      mem_addr_r   <= 32'h0000_0000;
      mem_pc_r     <= 32'h0000_0000;
      mem_wd_r     <= 32'h0000_0000;
      mem_we_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_next_s;
      mem_we_r     <= mem_we_next_s;
      mem_wd_r     <= mem_wd_next_s;
      resp_valid_r <= resp_valid_next_s;
      resp_err_r   <= resp_err_next_s;
      resp_rdata_r <= resp_rdata_next_s;
      if (accept_s) begin
        we_r       <= req_we;
        sign_r     <= req_sign;
        size_r     <= req_size;
        off_r      <= req_addr[1:0];
        wdata_r    <= req_wdata[15:0];
        mem_addr_r <= {req_addr[31:2], 2'b00};
        mem_pc_r   <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Testbench for dm_access_unit: directed scenarios followed by randomized
// requests. Expected values come from a byte-lane memory model kept in the bench.
module tb_dm_access_unit;

  localparam int MEM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_pc, mem_rd;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  // The memory seen by the DUT, and the reference contents the model predicts.
  logic [31:0] mem     [0:MEM_WORDS-1] = '{default: 32'h0};
  logic [31:0] ref_mem [0:MEM_WORDS-1] = '{default: 32'h0};

  always #5 clk = ~clk;

  dm_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_pc(mem_pc),
    .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr[13:2]] <= mem_wd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: predicts the result, latency and write count, and updates ref_mem.
  task automatic model_req(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata,
                           output int lat, output int writes);
    longint unsigned nbits, off, word, mask, val;
    int widx;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= MEM_WORDS);
    rdata = 32'h0; lat = 1; writes = 0;
    if (err) return;
    nbits = longint'(8) << size;
    off   = longint'(addr % 4) * 8;
    widx  = int'(addr / 4);
    word  = {32'h0, ref_mem[widx]};
    mask  = (64'd1 << nbits) - 64'd1;
    if (!we) begin
      val = (word >> off) & mask;
      if (sign && val >= (mask + 64'd1) / 2) val = val - (mask + 64'd1);
      rdata = val[31:0];
      lat = 2;
    end else begin
      word = (word & ~(mask << off)) | (({32'h0, wdata} & mask) << off);
      ref_mem[widx] = word[31:0];
      lat = (nbits == 64'd32) ? 2 : 3;
      writes = 1;
    end
  endtask

  // Issue one request and check its handshake, latency, response and memory effect.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output int wait_cyc);
    logic exp_err;
    logic [31:0] exp_rdata, pc;
    int exp_lat, exp_wr, n, wr;
    bit ready_low, addr_ok, pc_ok, got_resp;
    pc = $urandom;
    model_req(we, size, sign, addr, wdata, exp_err, exp_rdata, exp_lat, exp_wr);
    req_we = we; req_size = size; req_sign = sign; req_addr = addr;
    req_wdata = wdata; req_pc = pc; req_valid = 1'b1;
    wait_cyc = 0;
    while (req_ready !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_cnt++;
    if (req_ready !== 1'b1) begin
      $display("FAIL accept: req_ready=%b, required 1 within 20 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    // Garbage on the request inputs while busy must be ignored.
    req_we = 1'($urandom); req_size = 2'($urandom); req_sign = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
    n = 1; wr = 0; ready_low = 1; addr_ok = 1; got_resp = 0;
    pc_ok = (mem_pc === pc);
    while (n <= 8) begin
      if (req_ready !== 1'b0) ready_low = 0;
      if (mem_we === 1'b1) begin
        wr++;
        if (mem_addr !== {addr[31:2], 2'b00}) addr_ok = 0;
      end
      if (resp_valid === 1'b1) begin
        got_resp = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    last_rdata = resp_rdata;
    last_err   = resp_err;
    check_cnt++;
    if (!got_resp || n != exp_lat) $display("FAIL latency @%h: got %0d cycles, required %0d", addr, n, exp_lat);
    else pass_cnt++;
    check_cnt++;
    if (resp_rdata !== exp_rdata) $display("FAIL rdata @%h: got %h, required %h", addr, resp_rdata, exp_rdata);
    else pass_cnt++;
    check_cnt++;
    if (resp_err !== exp_err) $display("FAIL err @%h: got %b, required %b", addr, resp_err, exp_err);
    else pass_cnt++;
    check_cnt++;
    if (wr != exp_wr) $display("FAIL write_count @%h: got %0d, required %0d", addr, wr, exp_wr);
    else pass_cnt++;
    check_cnt++;
    if (!(ready_low && addr_ok && pc_ok)) $display("FAIL busy_signals @%h: ready_low=%0d addr_ok=%0d pc_ok=%0d, required all 1", addr, ready_low, addr_ok, pc_ok);
    else pass_cnt++;
    if (!exp_err) begin
      check_cnt++;
      if (mem[addr[13:2]] !== ref_mem[addr[13:2]]) $display("FAIL mem_word @%h: got %h, required %h", addr, mem[addr[13:2]], ref_mem[addr[13:2]]);
      else pass_cnt++;
    end
    if (!hold) begin
      @(negedge clk);
      check_cnt++;
      if (resp_valid !== 1'b0) $display("FAIL resp_pulse @%h: resp_valid=%b one cycle later, required 0", addr, resp_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b0000) $display("FAIL reset_flags: got %b, required 0000", {req_ready, resp_valid, resp_err, mem_we});
    else pass_cnt++;
    check_cnt++;
    if ({resp_rdata, mem_addr, mem_wd, mem_pc} !== 128'h0) $display("FAIL reset_data: got %h, required 0", {resp_rdata, mem_addr, mem_wd, mem_pc});
    else pass_cnt++;
    reset = 1'b0;
    #1;
    check_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    int w;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 1'b0, w);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, w);
    check_cnt++;
    if (last_rdata !== 32'h1234_5678 || last_err !== 1'b0) $display("FAIL lw_after_sw: got %h err %b, required 12345678 err 0", last_rdata, last_err);
    else pass_cnt++;
  endtask

  task automatic test_byte_rmw();
    int w;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD, 1'b0, w);
    do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_0011, 1'b0, w);
    check_cnt++;
    if (mem[8] !== 32'hAA11_CCDD) $display("FAIL sb_merge: got %h, required aa11ccdd", mem[8]);
    else pass_cnt++;
  endtask

  task automatic test_extension();
    int w;
    logic [31:0] exp_tab [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_CCDD, 32'h0000_AA11};
    logic [31:0] addr_tab [4] = '{32'h23, 32'h23, 32'h20, 32'h22};
    logic [1:0]  size_tab [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sign_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, size_tab[i], sign_tab[i], addr_tab[i], 32'h0, 1'b0, w);
      check_cnt++;
      if (last_rdata !== exp_tab[i]) $display("FAIL extend_%0d: got %h, required %h", i, last_rdata, exp_tab[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors();
    int w;
    logic        we_tab   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  size_tab [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [31:0] addr_tab [4] = '{32'h21, 32'h03, 32'h4000, 32'h30};
    for (int i = 0; i < 4; i++) begin
      do_req(we_tab[i], size_tab[i], 1'b1, addr_tab[i], 32'hDEAD_BEEF, 1'b0, w);
      check_cnt++;
      if (last_err !== 1'b1 || last_rdata !== 32'h0) $display("FAIL error_%0d: got err %b rdata %h, required err 1 rdata 0", i, last_err, last_rdata);
      else pass_cnt++;
    end
    check_cnt++;
    if (mem[0] !== ref_mem[0]) $display("FAIL oor_store_alias: word0 %h, required %h", mem[0], ref_mem[0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, w1);
    do_req(1'b1, 2'b00, 1'b0, 32'h24, 32'h0000_005A, 1'b0, w2);
    check_cnt++;
    if (w2 != 1) $display("FAIL b2b_spacing: second request waited %0d cycles, required 1", w2);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_merge();
    bit no_resp;
    req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0; req_addr = 32'h21;
    req_wdata = 32'h55; req_pc = 32'h100; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (mem_we !== 1'b1) $display("FAIL merge_reached: mem_we=%b in MERGE, required 1", mem_we);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++;
    if (mem_we !== 1'b0) $display("FAIL reset_gates_we: mem_we=%b, required 0", mem_we);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({resp_valid, mem_we, req_ready} !== 3'b000) $display("FAIL reset_mid_op: got %b, required 000", {resp_valid, mem_we, req_ready});
    else pass_cnt++;
    reset = 1'b0;
    #1;
    check_cnt++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b, required 1", req_ready);
    else pass_cnt++;
    no_resp = 1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_we !== 1'b0) no_resp = 0;
    end
    check_cnt++;
    if (!no_resp) $display("FAIL abandoned_quiet: response or write seen, required none");
    else pass_cnt++;
    check_cnt++;
    if (mem[8] !== ref_mem[8]) $display("FAIL abandoned_mem: got %h, required %h", mem[8], ref_mem[8]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int w;
    logic [31:0] addr;
    bit hold;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0001_0000;
      else addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      hold = (i < 59) && ($urandom_range(0, 1) == 1);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom, hold, w);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_extension();
    test_errors();
    test_back_to_back();
    test_reset_in_merge();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
